// File: rtl/acc_writeback_pkg.sv
// Shared definitions for the IL execute-stage write-back: opcode and
// state encodings plus the read-modify-write bit merge.
package acc_writeback_pkg;

    localparam int unsigned wbOpcodeLen = 3;
    localparam int unsigned DataW       = 8;
    localparam int unsigned AddrW       = 8;

    typedef enum logic [wbOpcodeLen-1:0] {
        WB_NOP   = 3'd0,
        WB_ACC   = 3'd1,
        WB_ACC_C = 3'd2,
        WB_ST    = 3'd3,
        WB_STN   = 3'd4,
        WB_S     = 3'd5,
        WB_R     = 3'd6,
        WB_ILL   = 3'd7
    } wb_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        RMW_READ  = 2'd2,
        RMW_WRITE = 2'd3
    } wb_state_e;

    // Force one bit of a read-back byte high (set=1) or low (set=0).
    function automatic logic [DataW-1:0] merge_bit(input logic [DataW-1:0] data,
                                                   input logic [2:0]       idx,
                                                   input logic             set);
        logic [DataW-1:0] r;
        r      = data;
        r[idx] = set;
        return r;
    endfunction

endpackage

// File: rtl/acc_writeback.sv
// Accumulator/carry owner and data-memory side-effect engine (ST, STN,
// S, R) with a valid/ready stall while a memory transaction is open.
module acc_writeback
    import acc_writeback_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [wbOpcodeLen-1:0] wbOp,
    input  logic [DataW-1:0]       aluOut,
    input  logic                   carryOut,
    input  logic [AddrW-1:0]       addr,
    input  logic [2:0]             bitSel,
    output logic [DataW-1:0]       accOut,
    output logic                   carryFlag,
    output logic                   memReq,
    output logic                   memWe,
    output logic [AddrW-1:0]       memAddr,
    output logic [DataW-1:0]       memWData,
    input  logic                   memAck,
    input  logic [DataW-1:0]       memRData,
    output logic                   errOut
);

    wb_state_e        state_q, state_d;
    logic [DataW-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    logic [2:0]       bit_q, bit_d;
    logic             set_q, set_d;
    logic             accept;
    wb_op_e           op;

    assign op     = wb_op_e'(wbOp);
    assign accept = inValid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bit_d   = bit_q;
        set_d   = set_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (op)
                        WB_NOP: ;
                        WB_ACC: acc_d = aluOut;
                        WB_ACC_C: begin
                            acc_d   = aluOut;
                            carry_d = carryOut;
                        end
                        WB_ST, WB_STN: begin
                            addr_d  = addr;
                            wdata_d = (op == WB_STN) ? ~acc_q : acc_q;
                            we_d    = 1'b1;
                            state_d = WRITE;
                        end
                        WB_S, WB_R: begin
                            addr_d  = addr;
                            we_d    = 1'b0;
                            bit_d   = bitSel;
                            set_d   = (op == WB_S);
                            state_d = RMW_READ;
                        end
                        WB_ILL: err_d = 1'b1;
                    endcase
                end
            end
            RMW_READ: begin
                if (memAck) begin
                    wdata_d = merge_bit(memRData, bit_q, set_q);
                    we_d    = 1'b1;
                    state_d = RMW_WRITE;
                end
            end
            WRITE, RMW_WRITE: begin
                if (memAck) begin
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bit_q   <= '0;
            set_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bit_q   <= bit_d;
            set_q   <= set_d;
        end
    end

    // Request and ready come straight from the state register, so a reset
    // drops memReq asynchronously and inReady never depends on inValid.
    assign inReady   = (state_q == IDLE);
    assign memReq    = (state_q != IDLE);
    assign memWe     = we_q;
    assign memAddr   = addr_q;
    assign memWData  = wdata_q;
    assign accOut    = acc_q;
    assign carryFlag = carry_q;
    assign errOut    = err_q;

endmodule

// File: tb/tb_acc_writeback.sv
// Scenario bench for acc_writeback with a scoreboarded memory responder.
module tb_acc_writeback;
    import acc_writeback_pkg::*;

    logic       clk, reset_n, inValid, inReady, carryOut, carryFlag;
    logic [2:0] wbOp, bitSel;
    logic [7:0] aluOut, addr, accOut, memAddr, memWData, memRData;
    logic       memReq, memWe, memAck, errOut;

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ack_delay = 0;
    int unsigned wait_cnt = 0;
    logic [7:0]  rd_data = 8'h00;
    logic        stray_ack = 1'b0;

    acc_writeback dut (
        .clk(clk), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
        .wbOp(wbOp), .aluOut(aluOut), .carryOut(carryOut), .addr(addr),
        .bitSel(bitSel), .accOut(accOut), .carryFlag(carryFlag),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData), .errOut(errOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: checks each open request against the scoreboard
    // head every cycle (so it also checks hold stability), acks after ack_delay.
    initial begin
        memAck   = 1'b0;
        memRData = 8'h00;
        forever begin
            @(negedge clk);
            memAck = 1'b0;
            if (memReq === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_req: addr=%h we=%b, none expected", memAddr, memWe);
                end else if (memAddr !== exp_q[0].a ||
                             (memWe === 1'b1 && memWData !== exp_q[0].d)) begin
                    errors++;
                    $display("FAIL sb_req: addr=%h data=%h we=%b, expected addr=%h data=%h",
                             memAddr, memWData, memWe, exp_q[0].a, exp_q[0].d);
                end
                if (memWe !== 1'b1) memRData = rd_data;
                if (wait_cnt >= ack_delay) begin
                    memAck   = 1'b1;
                    wait_cnt = 0;
                    if (memWe === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                memAck   = stray_ack;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] alu, input logic c,
                         input logic [7:0] a, input logic [2:0] b);
        int unsigned n = 0;
        @(negedge clk);
        while (inReady !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (inReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: inReady=%b, expected 1", inReady);
        end
        inValid = 1'b1; wbOp = op; aluOut = alu; carryOut = c; addr = a; bitSel = b;
        @(posedge clk);
        #1;
        inValid = 1'b0; wbOp = WB_NOP;
    endtask

    task automatic wait_idle(output int unsigned busy);
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (inReady === 1'b1) return;
            busy++;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle_timeout: still busy after %0d cycles, expected idle", busy);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; inValid = 1'b0; wbOp = WB_NOP; aluOut = '0; carryOut = 1'b0;
        addr = '0; bitSel = '0;
        repeat (2) @(negedge clk);
        inValid = 1'b1; wbOp = WB_ACC_C; aluOut = 8'h77; carryOut = 1'b1;
        @(negedge clk);
        checks++;
        if ({accOut, carryFlag, errOut, memReq, memWe, memAddr, memWData, inReady} !==
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: acc=%h c=%b err=%b req=%b we=%b ma=%h wd=%h rdy=%b, expected 00 0 0 0 0 00 00 1",
                     accOut, carryFlag, errOut, memReq, memWe, memAddr, memWData, inReady);
        end
        inValid = 1'b0; wbOp = WB_NOP;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (accOut !== 8'h00 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: acc=%h rdy=%b, expected 00 1", accOut, inReady);
        end
    endtask

    task automatic test_acc();
        issue(WB_ACC_C, 8'hFF, 1'b1, 8'h00, 3'd0);
        checks++;
        if (accOut !== 8'hFF || carryFlag !== 1'b1) begin
            errors++;
            $display("FAIL acc_c: acc=%h c=%b, expected ff 1", accOut, carryFlag);
        end
        issue(WB_ACC, 8'h12, 1'b0, 8'h00, 3'd0);
        checks++;
        if (accOut !== 8'h12 || carryFlag !== 1'b1) begin
            errors++;
            $display("FAIL acc_keep_carry: acc=%h c=%b, expected 12 1", accOut, carryFlag);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        logic [2:0] ops  [3];
        logic       exp_c;
        vals = '{8'h01, 8'h80, 8'h02};
        ops  = '{WB_ACC, WB_ACC_C, WB_ACC};
        exp_c = carryFlag;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], vals[i], 1'b0, 8'h00, 3'd0);
            if (ops[i] == WB_ACC_C) exp_c = 1'b0;
            checks++;
            if (accOut !== vals[i] || carryFlag !== exp_c || inReady !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d: acc=%h c=%b rdy=%b, expected %h %b 1",
                         i, accOut, carryFlag, inReady, vals[i], exp_c);
            end
        end
    endtask

    task automatic test_st();
        int unsigned busy;
        issue(WB_ACC, 8'h5A, 1'b0, 8'h00, 3'd0);
        ack_delay = 3;
        exp_q.push_back('{a: 8'h20, d: 8'h5A});
        issue(WB_ST, 8'hEE, 1'b1, 8'h20, 3'd0);
        checks++;
        if ({memReq, memWe, memAddr, memWData, inReady} !== {1'b1, 1'b1, 8'h20, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL st_start: req=%b we=%b ma=%h wd=%h rdy=%b, expected 1 1 20 5a 0",
                     memReq, memWe, memAddr, memWData, inReady);
        end
        wait_idle(busy);
        checks++;
        if (busy !== 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL st_occupancy: busy=%0d pending=%0d, expected 4 0", busy, exp_q.size());
        end
        checks++;
        if (memReq !== 1'b0 || memWe !== 1'b0 || accOut !== 8'h5A) begin
            errors++;
            $display("FAIL st_end: req=%b we=%b acc=%h, expected 0 0 5a", memReq, memWe, accOut);
        end
    endtask

    task automatic test_rmw();
        int unsigned busy;
        ack_delay = 0;
        rd_data = 8'h01;
        exp_q.push_back('{a: 8'h10, d: 8'h81});
        issue(WB_S, 8'h00, 1'b0, 8'h10, 3'd7);
        checks++;
        if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 8'h10) begin
            errors++;
            $display("FAIL s_read: req=%b we=%b ma=%h, expected 1 0 10", memReq, memWe, memAddr);
        end
        wait_idle(busy);
        checks++;
        if (busy !== 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL s_occupancy: busy=%0d pending=%0d, expected 2 0", busy, exp_q.size());
        end
        rd_data = 8'h81;
        exp_q.push_back('{a: 8'h10, d: 8'h80});
        issue(WB_R, 8'h00, 1'b0, 8'h10, 3'd0);
        wait_idle(busy);
        checks++;
        if (busy !== 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL r_occupancy: busy=%0d pending=%0d, expected 2 0", busy, exp_q.size());
        end
    endtask

    task automatic test_stn();
        int unsigned busy;
        ack_delay = 0;
        issue(WB_ACC, 8'h0F, 1'b0, 8'h00, 3'd0);
        exp_q.push_back('{a: 8'h33, d: 8'hF0});
        issue(WB_STN, 8'h00, 1'b0, 8'h33, 3'd0);
        checks++;
        if (memWData !== 8'hF0 || memWe !== 1'b1) begin
            errors++;
            $display("FAIL stn_data: wd=%h we=%b, expected f0 1", memWData, memWe);
        end
        wait_idle(busy);
        checks++;
        if (busy !== 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stn_occupancy: busy=%0d pending=%0d, expected 1 0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int unsigned n = 0;
        ack_delay = 4;
        rd_data = 8'h00;
        exp_q.push_back('{a: 8'h44, d: 8'h08});
        issue(WB_S, 8'h00, 1'b0, 8'h44, 3'd3);
        @(negedge clk);
        while (memWe !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (memWe !== 1'b1 || memReq !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_write: we=%b req=%b, expected 1 1", memWe, memReq);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({accOut, carryFlag, errOut, memReq, memWe, memAddr, memWData, inReady} !==
            {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: acc=%h c=%b err=%b req=%b we=%b ma=%h wd=%h rdy=%b, expected 00 0 0 0 0 00 00 1",
                     accOut, carryFlag, errOut, memReq, memWe, memAddr, memWData, inReady);
        end
        exp_q.delete();
        ack_delay = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (inReady !== 1'b1 || memReq !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: rdy=%b req=%b, expected 1 0", inReady, memReq);
        end
    endtask

    task automatic test_err();
        issue(WB_ACC, 8'h3C, 1'b0, 8'h00, 3'd0);
        issue(3'd7, 8'hAA, 1'b1, 8'h55, 3'd2);
        checks++;
        if ({errOut, accOut, carryFlag, memReq, memWe, memAddr, inReady} !==
            {1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL err_set: err=%b acc=%h c=%b req=%b we=%b ma=%h rdy=%b, expected 1 3c 0 0 0 00 1",
                     errOut, accOut, carryFlag, memReq, memWe, memAddr, inReady);
        end
        issue(WB_NOP, 8'h99, 1'b1, 8'h00, 3'd0);
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (errOut !== 1'b1 || accOut !== 8'h3C || inReady !== 1'b1 || memReq !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: err=%b acc=%h rdy=%b req=%b, expected 1 3c 1 0",
                     errOut, accOut, inReady, memReq);
        end
        stray_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (errOut !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, expected 0", errOut);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_acc();
        test_back_to_back();
        test_st();
        test_rmw();
        test_stn();
        test_reset_mid();
        test_err();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
